// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// captures the fetched word into the IF/ID register, with stall/flush/redirect.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] im_addr,
  input  logic [31:0] im_data,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        running,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
);

  localparam int unsigned XLEN = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   pc4_q, pc4_d;
  logic              valid_q, valid_d;
  logic              running_q;
  logic [XLEN-1:0]   fetch_cnt_q, fetch_cnt_d;
  logic [XLEN-1:0]   stall_cnt_q, stall_cnt_d;

  logic              redirect_c;
  logic [XLEN-1:0]   target_c;
  logic [XLEN-1:0]   pc_plus4_c;

  // Redirect target: branch beats jump, always word aligned.
  assign redirect_c = branch_taken | jump;
  assign target_c   = (branch_taken ? branch_target : jump_target) & ~XLEN'(3);
  assign pc_plus4_c = pc_q + XLEN'(4);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        // IF/ID already holds a bubble here; stall and flush have no effect.
        if (redirect_c) pc_d = target_c;
        if (fetch_en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!fetch_en) begin
          state_d = ST_IDLE;
          if (redirect_c) pc_d = target_c;
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end else if (redirect_c) begin
          pc_d    = target_c;
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end else if (stall) begin
          stall_cnt_d = stall_cnt_q + XLEN'(1);
          if (flush) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
          end
        end else begin
          pc_d = pc_plus4_c;
          if (flush) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
          end else begin
            instr_d     = im_data;
            pc4_d       = pc_plus4_c;
            valid_d     = 1'b1;
            fetch_cnt_d = fetch_cnt_q + XLEN'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      instr_q     <= NOP_WORD;
      pc4_q       <= '0;
      valid_q     <= 1'b0;
      running_q   <= 1'b0;
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
      running_q   <= (state_d == ST_RUN);
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign im_addr     = pc_q;
  assign pc          = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign running     = running_q;
  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a stimulus process predicts each edge's
// architectural state from the fetch rules; a monitor compares after the edge.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, fetch_en, stall, flush, branch_taken, jump;
  logic [31:0] branch_target, jump_target;
  logic [31:0] im_addr, im_data, pc, if_id_instr, if_id_pc4;
  logic        if_id_valid, running;
  logic [31:0] fetch_count, stall_count;

  if_stage #(.RESET_PC(RESET_PC), .NOP_WORD(NOP_WORD)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .im_addr(im_addr), .im_data(im_data), .pc(pc),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
    .running(running), .fetch_count(fetch_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Instruction memory: three fixed program words, a scrambled pattern elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h2001_0005;
      32'h4:   return 32'h2002_0003;
      32'h8:   return 32'h0022_1820;
      default: return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  assign im_data = mem_word(im_addr);

  typedef struct {
    logic [31:0] pc, instr, pc4, fc, sc;
    logic        valid, run, chk_pc4;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state of the fetch stage
  logic [31:0] m_pc = RESET_PC, m_instr = NOP_WORD, m_pc4 = 0, m_fc = 0, m_sc = 0;
  logic        m_valid = 0, m_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic bubble();
    m_valid = 1'b0;
    m_instr = NOP_WORD;
  endtask

  // Drive one cycle of inputs at the falling edge and predict the next edge.
  task automatic step(input logic r, input logic fen, input logic st, input logic fl,
                      input logic br, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt);
    exp_t        e;
    logic [31:0] tgt;
    @(negedge clk);
    rst = r; fetch_en = fen; stall = st; flush = fl;
    branch_taken = br; branch_target = bt; jump = j; jump_target = jt;
    tgt = (br ? bt : jt);
    tgt[1:0] = 2'b00;
    if (r) begin
      m_pc = RESET_PC; m_pc4 = 0; m_fc = 0; m_sc = 0; m_run = 0;
      bubble();
    end else if (!m_run) begin
      if (br || j) m_pc = tgt;
      if (fen) m_run = 1'b1;
    end else if (!fen) begin
      m_run = 1'b0;
      if (br || j) m_pc = tgt;
      bubble();
    end else if (br || j) begin
      m_pc = tgt;
      bubble();
    end else if (st) begin
      m_sc = m_sc + 1;
      if (fl) bubble();
    end else begin
      if (fl) bubble();
      else begin
        m_instr = mem_word(m_pc);
        m_pc4   = m_pc + 4;
        m_valid = 1'b1;
        m_fc    = m_fc + 1;
      end
      m_pc = m_pc + 4;
    end
    e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.fc = m_fc; e.sc = m_sc;
    e.valid = m_valid; e.run = m_run; e.chk_pc4 = m_valid | r;
    exp_q.push_back(e);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare every predicted edge shortly after it happens.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc", pc, e.pc);
        chk("im_addr", im_addr, e.pc);
        chk("if_id_valid", 32'(if_id_valid), 32'(e.valid));
        chk("if_id_instr", if_id_instr, e.instr);
        if (e.chk_pc4) chk("if_id_pc4", if_id_pc4, e.pc4);
        chk("running", 32'(running), 32'(e.run));
        chk("fetch_count", fetch_count, e.fc);
        chk("stall_count", stall_count, e.sc);
      end
    end
  end

  initial begin
    rst = 1; fetch_en = 0; stall = 0; flush = 0;
    branch_taken = 0; jump = 0; branch_target = 0; jump_target = 0;
    // Reset, then the three-word program
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1, 32'h100, 1, 32'h200);
    run_cycles(3);                               // enter RUN, load word@0, word@4 -> pc=8
    step(0, 1, 1, 0, 0, 0, 0, 0);                // stall twice at pc=8
    step(0, 1, 1, 0, 0, 0, 0, 0);
    run_cycles(1);                               // word@8, pc=C
    step(0, 1, 1, 0, 1, 32'h40, 1, 32'h80);      // redirect beats stall
    run_cycles(1);                               // word@40
    step(0, 1, 0, 1, 0, 0, 0, 0);                // flush without stall
    step(0, 1, 1, 1, 0, 0, 0, 0);                // flush with stall
    step(0, 0, 0, 0, 0, 0, 0, 0);                // drop to IDLE
    step(0, 0, 1, 1, 0, 0, 0, 0);                // idle ignores stall/flush
    run_cycles(3);                               // resume, refetch held pc
    step(0, 1, 0, 0, 0, 0, 1, 32'hFFFF_FFFF);    // jump to aligned top of memory
    run_cycles(2);                               // wrap to 0
    step(0, 0, 0, 0, 1, 32'h0000_1003, 0, 0);    // redirect while leaving RUN
    step(0, 0, 0, 0, 0, 0, 1, 32'h0000_2002);    // redirect while IDLE
    run_cycles(3);
    step(1, 1, 0, 0, 0, 0, 0, 0);                // reset mid-run
    run_cycles(3);
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 9) == 0), $urandom,
           ($urandom_range(0, 9) == 0), $urandom);
    end
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the MIPS pipeline, directly upstream of the instruction memory.
- Owns the PC, drives the instruction memory address, and captures the returned word into the IF/ID pipeline register for decode.
- Handles pipeline stall, flush, branch/jump redirect and a run/idle fetch enable.
- Keeps fetch and stall performance counters.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- NOP_WORD, 32'h0000_0000: instruction word inserted into IF/ID on a bubble (sll $0,$0,0).

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_en  in  1  1 = fetch, 0 = go/stay idle.
- stall  in  1  hazard stall from decode; holds PC and IF/ID.
- flush  in  1  bubbles IF/ID on this edge.
- branch_taken  in  1  taken-branch redirect.
- branch_target  in  32  branch destination.
- jump  in  1  jump redirect.
- jump_target  in  32  jump destination.
- im_addr  out  32  address to instruction memory; equals pc.
- im_data  in  32  instruction word, combinational from memory for im_addr.
- pc  out  32  current fetch PC.
- if_id_instr  out  32  registered instruction for decode.
- if_id_pc4  out  32  registered PC+4 of that instruction.
- if_id_valid  out  1  1 = if_id_instr is a real fetched instruction.
- running  out  1  1 when FSM is in RUN.
- fetch_count  out  32  number of instructions loaded into IF/ID with valid=1.
- stall_count  out  32  number of RUN cycles with stall=1 and no redirect.

Behaviour:
- Reset (rst=1 at edge):
  - pc = RESET_PC; state = IDLE.
  - if_id_instr = NOP_WORD; if_id_pc4 = 0; if_id_valid = 0.
  - fetch_count = 0; stall_count = 0; running = 0.
  - rst overrides every other input. Reset mid-operation discards the IF/ID contents.
- im_addr = pc, combinational. The memory read is asynchronous, so im_data is the word at pc in the same cycle.
- Latency: the word at PC X appears on if_id_instr one edge after X is presented, with if_id_pc4 = X+4.
- Redirect:
  - redirect = branch_taken | jump.
  - Target = branch_target when branch_taken=1, else jump_target. branch_taken has priority when both are asserted.
  - Target bits [1:0] are forced to 00.
- FSM states: IDLE, RUN.
- IDLE:
  - IF/ID holds a bubble (valid=0, instr=NOP_WORD).
  - pc holds, except redirect loads the target.
  - fetch_en=1 at an edge -> RUN. No IF/ID load on that edge.
  - stall and flush are ignored.
- RUN, applied in priority order at each edge:
  - (a) fetch_en=0 -> IDLE. pc holds (or takes the redirect target if redirect=1). IF/ID is bubbled. The uncaptured word at pc is refetched on resume.
  - (b) redirect=1 -> pc = target; IF/ID bubbled (the wrong-path word is discarded). This applies even if stall=1: redirect beats stall.
  - (c) stall=1 -> pc and the whole IF/ID register hold unchanged; stall_count increments. If flush=1 in the same cycle, IF/ID is bubbled while pc still holds.
  - (d) Otherwise -> pc = pc+4. IF/ID is loaded with {im_data, pc+4, valid=1}, or with a bubble if flush=1.
- fetch_count increments on every edge where if_id_valid is loaded as 1.
- Arithmetic: pc+4 is 32-bit modulo, so 32'hFFFF_FFFC+4 = 0. Both counters wrap modulo 2^32.
- The PC is never range-checked. Memory aliasing above the memory size is the memory's concern.
- running = (state == RUN), registered.

Test Plan:
- Reset, fetch_en=1, memory words 0:32'h2001_0005, 4:32'h2002_0003, 8:32'h0022_1820 -> after edges 2, 3, 4: if_id_instr = 20010005 / 20020003 / 00221820, if_id_pc4 = 4 / 8 / C, fetch_count=3.
- Stall: while RUN at pc=8, hold stall=1 for 2 cycles -> pc stays 8, IF/ID unchanged, stall_count=2; after release, next IF/ID = {word@8, pc4=C}.
- Redirect: at pc=C assert branch_taken=1, branch_target=32'h40, with jump=1, jump_target=32'h80 and stall=1 in the same cycle -> pc=40, if_id_valid=0, stall_count unchanged. The next edge captures word@40 with pc4=44.
- Flush without stall at pc=10 -> if_id_valid=0, if_id_instr=NOP_WORD, pc=14, fetch_count unchanged.
- fetch_en dropped at pc=20 -> running=0 next edge, pc stays 20, IF/ID bubble. Re-enable -> first valid IF/ID is word@20 two edges later.
- Wrap and reset mid-run: force redirect target 32'hFFFF_FFFF -> pc=FFFF_FFFC, then pc=0 and if_id_pc4=0 on the following edge. Assert rst mid-RUN -> next edge pc=RESET_PC, state IDLE, valid=0, both counters 0.
